// File: rtl/apb_master_if.sv
// apb_master_if: bundles the command channel, response channel and APB bus of apb_master.
//   cmd_*  : upstream command channel (valid/ready)
//   rsp_*  : upstream response channel (valid/ready)
//   p*     : APB requester signals toward the peripheral
// Modport master is the requester's view; modport slave is the view of the surrounding
// environment (command source, response sink and APB completer).
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [StrbW-1:0]      cmd_strb;

  // Response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [StrbW-1:0]      pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
//   pclk    : clock
//   presetn : asynchronous active-low reset
//   bus     : apb_master_if.master
//             cmd_*  accepted only in IDLE (cmd_ready registered)
//             p*     SETUP/ACCESS sequencing, waits on pready
//             rsp_*  read data / error / timeout held until rsp_ready
// A wait-state watchdog aborts ACCESS after TIMEOUT cycles of pready low (0 disables it).
// All outputs are registers, so no input reaches cmd_ready or rsp_valid combinationally.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic          pclk,
  input logic          presetn,
  apb_master_if.master bus
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       wd_cnt_q, wd_cnt_d;

  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [StrbW-1:0]      pstrb_q, pstrb_d;

  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;

  logic                  wd_hit;

  // This ACCESS cycle is the TIMEOUT-th one; aborts only if pready is still low.
  assign wd_hit = (TIMEOUT != 0) && (32'(wd_cnt_q) == (TIMEOUT - 32'd1));

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        wd_cnt_d = '0;
        state_d  = StAccess;
      end
      StAccess: begin
        // Completion takes priority over a watchdog hit in the same cycle.
        if (bus.pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (wd_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          wd_cnt_d = wd_cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    cmd_ready_d = (state_d == StIdle);
    psel_d      = (state_d == StSetup) || (state_d == StAccess);
    penable_d   = (state_d == StAccess);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= StIdle;
      wd_cnt_q      <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_cnt_q      <= wd_cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector table plus randomized transactions for apb_master,
// with a transaction-level reference model and an APB completer driven per ACCESS cycle.
module tb_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int         TO = 16;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;      // ACCESS cycles with pready low before completion
    logic        slverr;
    logic [31:0] prd;
    int          rsp_delay;  // cycles rsp_ready is held low once rsp_valid appears
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;    // expected number of ACCESS cycles
  } vec_t;

  logic pclk;
  logic presetn;
  int   checks;
  int   errors;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int wt, input logic e,
                              input logic [31:0] p, input int dly, input logic [31:0] xr,
                              input logic xe, input logic xt, input int xa);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.strb = s; v.waits = wt; v.slverr = e;
    v.prd = p; v.rsp_delay = dly; v.exp_rdata = xr; v.exp_err = xe; v.exp_to = xt;
    v.exp_acc = xa;
    return v;
  endfunction

  // Transaction-level model: the slave answers on ACCESS cycle waits+1 unless the
  // watchdog's TO-cycle budget runs out first.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.waits + 1 <= TO) begin
      r.exp_acc   = v.waits + 1;
      r.exp_rdata = v.write ? 32'h0 : v.prd;
      r.exp_err   = v.slverr;
      r.exp_to    = 1'b0;
    end else begin
      r.exp_acc   = TO;
      r.exp_rdata = 32'h0;
      r.exp_err   = 1'b1;
      r.exp_to    = 1'b1;
    end
    return r;
  endfunction

  // Runs one command end to end; abort_at != 0 pulls reset on that ACCESS cycle.
  task automatic run_txn(input vec_t v, input int abort_at);
    int          acc;
    int          setup;
    int          lat;
    int          guard;
    bit          done;
    logic [31:0] exp_strb;
    exp_strb = v.write ? {28'h0, v.strb} : 32'h0;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("cmd_ready_before_accept", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.rsp_ready = (v.rsp_delay == 0);
    bus.pready    = 1'b0;
    tick();
    // A different command stays offered while busy; it must be ignored.
    bus.cmd_write = ~v.write;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_strb  = ~v.strb;
    acc = 0; setup = 0; lat = 0; done = 0;
    while (!done && lat < 100) begin
      lat++;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b1;
      bus.prdata  = $urandom;
      if (bus.rsp_valid) begin
        done = 1;
      end else begin
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        if (bus.psel && !bus.penable) begin
          setup++;
        end else if (bus.psel && bus.penable) begin
          acc++;
          chk("paddr_stable", bus.paddr, v.addr);
          chk("pwrite_stable", bus.pwrite, v.write);
          chk("pwdata_stable", bus.pwdata, v.wdata);
          chk("pstrb_stable", bus.pstrb, exp_strb);
          if (abort_at != 0 && acc == abort_at) begin
            presetn = 1'b0;
            #1;
            chk("async_reset_psel", bus.psel, 0);
            chk("async_reset_penable", bus.penable, 0);
            chk("async_reset_cmd_ready", bus.cmd_ready, 0);
            bus.cmd_valid = 1'b0;
            bus.pready    = 1'b0;
            bus.pslverr   = 1'b0;
            repeat (2) tick();
            presetn = 1'b1;
            repeat (4) begin
              tick();
              chk("no_rsp_after_reset", bus.rsp_valid, 0);
              chk("no_apb_after_reset", bus.psel, 0);
            end
            bus.rsp_ready = 1'b0;
            return;
          end
          if (acc > v.waits) begin
            bus.pready  = 1'b1;
            bus.pslverr = v.slverr;
            bus.prdata  = v.prd;
          end
        end
        tick();
      end
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    chk("rsp_valid_seen", done, 1);
    chk("setup_cycles", setup, 1);
    chk("access_cycles", acc, v.exp_acc);
    chk("rsp_latency", lat, v.exp_acc + 2);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", bus.rsp_err, v.exp_err);
    chk("rsp_timeout", bus.rsp_timeout, v.exp_to);
    chk("resp_psel_low", {bus.psel, bus.penable}, 0);
    for (int i = 0; i < v.rsp_delay; i++) begin
      tick();
      chk("rsp_valid_held", bus.rsp_valid, 1);
      chk("rsp_hold_rdata", bus.rsp_rdata, v.exp_rdata);
      chk("rsp_hold_flags", {bus.rsp_err, bus.rsp_timeout}, {v.exp_err, v.exp_to});
      chk("cmd_ready_in_resp", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 0);
    chk("cmd_ready_after_resp", bus.cmd_ready, 1);
  endtask

  vec_t dir[7];

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    // Directed table: inputs and hand-derived expectations.
    dir[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h12345678, 0, 32'h0, 0, 0, 1);
    dir[1] = mk(0, 32'h20, 32'h0, 4'hF, 3, 0, 32'hA5A50001, 0, 32'hA5A50001, 0, 0, 4);
    dir[2] = mk(0, 32'h30, 32'h0, 4'h0, 0, 1, 32'h00000055, 5, 32'h00000055, 1, 0, 1);
    dir[3] = mk(0, 32'h40, 32'h0, 4'hF, 100, 0, 32'h1, 0, 32'h0, 1, 1, 16);
    dir[4] = mk(0, 32'h44, 32'h0, 4'hF, 15, 0, 32'hCAFE0016, 0, 32'hCAFE0016, 0, 0, 16);
    dir[5] = mk(1, 32'h50, 32'h01234567, 4'h3, 2, 1, 32'hFFFFFFFF, 1, 32'h0, 1, 0, 3);
    dir[6] = mk(1, 32'h60, 32'h89ABCDEF, 4'h5, 16, 0, 32'h0, 2, 32'h0, 1, 1, 16);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h99;
    bus.cmd_wdata = 32'h55AA55AA;
    bus.cmd_strb  = 4'hF;
    bus.rsp_ready = 1'b1;
    bus.prdata    = 32'h0;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    presetn       = 1'b1;
    #1 presetn = 1'b0;

    // Reset held 3 cycles with a command offered.
    repeat (3) begin
      tick();
      chk("reset_outputs_zero", |{bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
          bus.rsp_timeout, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
          bus.pstrb}, 0);
    end
    presetn = 1'b1;
    tick();
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);
    chk("no_apb_after_reset_release", bus.psel, 0);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_txn(dir[i], 0);

    // Reset while waiting on pready, then a normal command.
    v = mk(0, 32'h70, 32'h0, 4'hF, 100, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    run_txn(v, 3);
    run_txn(dir[0], 0);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      v.write     = 1'($urandom);
      v.addr      = $urandom;
      v.wdata     = $urandom;
      v.strb      = 4'($urandom);
      v.waits     = $urandom_range(0, 20);
      v.slverr    = ($urandom_range(0, 3) == 0);
      v.prd       = $urandom;
      v.rsp_delay = $urandom_range(0, 3);
      run_txn(model(v), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
